// File: rtl/soc_picorv32_bus_ctl.sv
// PicoRV32 bus fabric: routes each CPU access to BRAM, SPRAM or one Wishbone slave,
// one transaction at a time, with a slave watchdog and a sticky error capture port.
module soc_picorv32_bus_ctl #(
    parameter int WB_N     = 8,
    parameter int WB_DW    = 32,
    parameter int WB_AW    = 16,
    parameter int WB_AI    = 2,
    parameter int RAM_LAT  = 1,
    parameter int BRAM_AW  = 8,
    parameter int SPRAM_AW = 15,
    parameter int TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           pb_addr,
    input  logic [31:0]           pb_wdata,
    input  logic [3:0]            pb_wstrb,
    input  logic                  pb_valid,
    output logic [31:0]           pb_rdata,
    output logic                  pb_ready,
    output logic [BRAM_AW-1:0]    bram_addr,
    input  logic [31:0]           bram_rdata,
    output logic [31:0]           bram_wdata,
    output logic [3:0]            bram_wmsk,
    output logic                  bram_we,
    output logic [SPRAM_AW-1:0]   spram_addr,
    input  logic [31:0]           spram_rdata,
    output logic [31:0]           spram_wdata,
    output logic [3:0]            spram_wmsk,
    output logic                  spram_we,
    output logic [WB_AW-1:0]      wb_addr,
    output logic [WB_DW-1:0]      wb_wdata,
    output logic [WB_DW/8-1:0]    wb_wmsk,
    output logic                  wb_we,
    output logic [WB_N-1:0]       wb_cyc,
    input  logic [WB_DW*WB_N-1:0] wb_rdata,
    input  logic [WB_N-1:0]       wb_ack,
    input  logic                  err_clr,
    output logic                  err_flag,
    output logic [1:0]            err_code,
    output logic [31:0]           err_addr,
    output logic [1:0]            dbg_state
);
    localparam int          WB_SW    = WB_DW / 8;
    localparam logic [15:0] RAM_LAST = 16'(RAM_LAT - 1);
    localparam logic [15:0] WD_LAST  = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RAM, S_WB, S_DONE} state_t;

    state_t          state, state_nx;
    logic [15:0]     cnt, cnt_nx;
    logic [31:0]     rdata_q, rdata_nx;
    logic [31:0]     addr_q;
    logic            spram_sel, spram_sel_nx;
    logic [WB_N-1:0] cyc_nx;
    logic            wb_load;
    logic            err_ev;
    logic [1:0]      err_ev_code;
    logic [31:0]     err_ev_addr;

    logic             req, is_wb, is_spram, is_wr, wb_mapped, wb_hit;
    logic [3:0]       wb_idx;
    logic [WB_DW-1:0] wb_or;

    // Handshake: pb_valid is sampled only in IDLE; pb_ready pulses for exactly one
    // cycle in DONE with pb_rdata valid in that same cycle; the CPU holds the request
    // until then, and a new request is accepted no earlier than the following cycle.
    assign req       = (state == S_IDLE) && pb_valid;
    assign is_wb     = pb_addr[31];
    assign is_spram  = pb_addr[17];
    assign is_wr     = |pb_wstrb;
    assign wb_idx    = pb_addr[27:24];
    assign wb_mapped = {1'b0, wb_idx} < 5'(WB_N);
    assign wb_hit    = |(wb_ack & wb_cyc);

    always_comb begin
        wb_or = '0;
        for (int i = 0; i < WB_N; i++) wb_or = wb_or | wb_rdata[i*WB_DW +: WB_DW];
    end

    // RAM ports are driven straight from the request so the write lands in cycle 0.
    assign bram_addr   = pb_addr[BRAM_AW+1:2];
    assign bram_wdata  = pb_wdata;
    assign bram_we     = req && !is_wb && !is_spram && is_wr;
    assign bram_wmsk   = bram_we ? ~pb_wstrb : 4'h0;
    assign spram_addr  = pb_addr[SPRAM_AW+1:2];
    assign spram_wdata = pb_wdata;
    assign spram_we    = req && !is_wb && is_spram && is_wr;
    assign spram_wmsk  = spram_we ? ~pb_wstrb : 4'h0;

    assign pb_ready  = (state == S_DONE);
    assign pb_rdata  = pb_ready ? rdata_q : 32'h0;
    assign dbg_state = state;

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        rdata_nx     = rdata_q;
        spram_sel_nx = spram_sel;
        cyc_nx       = wb_cyc;
        wb_load      = 1'b0;
        err_ev       = 1'b0;
        err_ev_code  = 2'b00;
        err_ev_addr  = addr_q;
        case (state)
            S_IDLE: if (pb_valid) begin
                cnt_nx = '0;
                if (!is_wb) begin
                    state_nx     = S_RAM;
                    spram_sel_nx = is_spram;
                end else if (wb_mapped) begin
                    state_nx = S_WB;
                    wb_load  = 1'b1;
                    cyc_nx   = WB_N'(1) << wb_idx;
                end else begin
                    state_nx    = S_DONE;
                    rdata_nx    = 32'hFFFF_FFFF;
                    err_ev      = 1'b1;
                    err_ev_code = 2'b10;
                    err_ev_addr = pb_addr;
                end
            end
            S_RAM: begin
                if (cnt == RAM_LAST) begin
                    state_nx = S_DONE;
                    rdata_nx = spram_sel ? spram_rdata : bram_rdata;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            S_WB: begin
                // An ack in the final watchdog cycle still wins over the timeout.
                if (wb_hit) begin
                    state_nx = S_DONE;
                    rdata_nx = 32'(wb_or);
                    cyc_nx   = '0;
                end else if ((TIMEOUT != 0) && (cnt == WD_LAST)) begin
                    state_nx    = S_DONE;
                    rdata_nx    = 32'hFFFF_FFFF;
                    cyc_nx      = '0;
                    err_ev      = 1'b1;
                    err_ev_code = 2'b01;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rdata_q   <= '0;
            addr_q    <= '0;
            spram_sel <= 1'b0;
            wb_cyc    <= '0;
            wb_addr   <= '0;
            wb_wdata  <= '0;
            wb_wmsk   <= '0;
            wb_we     <= 1'b0;
            err_flag  <= 1'b0;
            err_code  <= 2'b00;
            err_addr  <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            rdata_q   <= rdata_nx;
            spram_sel <= spram_sel_nx;
            wb_cyc    <= cyc_nx;
            if (req) addr_q <= pb_addr;
            if (wb_load) begin
                wb_addr  <= pb_addr[WB_AI +: WB_AW];
                wb_wdata <= pb_wdata[WB_DW-1:0];
                wb_wmsk  <= ~pb_wstrb[WB_SW-1:0];
                wb_we    <= is_wr;
            end
            // A new error in the same cycle as err_clr is kept rather than cleared.
            if (err_ev && (!err_flag || err_clr)) begin
                err_flag <= 1'b1;
                err_code <= err_ev_code;
                err_addr <= err_ev_addr;
            end else if (err_clr) begin
                err_flag <= 1'b0;
                err_code <= 2'b00;
                err_addr <= '0;
            end
        end
    end
endmodule

// File: doc/soc_picorv32_bus_ctl.md
# soc_picorv32_bus_ctl

Second-generation PicoRV32 bus fabric: decodes each CPU access to BRAM, SPRAM or one of WB_N Wishbone slaves through a single-outstanding-transaction FSM. Adds what the first bridge lacks:

- configurable RAM read latency;
- fully registered Wishbone master stage;
- watchdog timeout on unresponsive slaves;
- immediate error completion for unmapped slave indexes;
- a sticky error/status capture port for firmware and debug.

It sits between the PicoRV32 core and all SoC memories and peripherals.

## Interface
Parameters
- WB_N, 8: number of Wishbone slaves, 1..16.
- WB_DW, 32: Wishbone data width, 8/16/32.
- WB_AW, 16: Wishbone word-address width.
- WB_AI, 2: lowest CPU address bit forwarded to wb_addr.
- RAM_LAT, 1: RAM read latency in cycles, 1 or 2.
- BRAM_AW, 8: BRAM word-address width.
- SPRAM_AW, 15: SPRAM word-address width.
- TIMEOUT, 255: maximum ack wait in cycles, 1..65535. 0 disables the watchdog.

Ports
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- pb_addr/pb_wdata  in  32  CPU address / write data.
- pb_wstrb  in  4  byte write strobes.
- pb_valid  in  1  request.
- pb_rdata  out  32  read data.
- pb_ready  out  1  completion pulse.
- bram_addr  out  BRAM_AW  BRAM word address.
- bram_rdata  in  32  BRAM read data.
- bram_wdata  out  32  BRAM write data.
- bram_wmsk  out  4  BRAM write mask, active-low.
- bram_we  out  1  BRAM write enable.
- spram_*  (same set, with spram_addr SPRAM_AW wide)  SPRAM equivalents.
- wb_addr  out  WB_AW  Wishbone word address.
- wb_wdata  out  WB_DW  Wishbone write data.
- wb_wmsk  out  WB_DW/8  Wishbone write mask, active-low (~pb_wstrb).
- wb_we  out  1  Wishbone write enable.
- wb_cyc  out  WB_N  one-hot cycle per slave.
- wb_rdata  in  WB_DW*WB_N  slave read data; slaves drive 0 when not acking.
- wb_ack  in  WB_N  slave acknowledges.
- err_clr  in  1  clears the error status.
- err_flag  out  1  sticky error status.
- err_code  out  2  01 = timeout, 10 = unmapped.
- err_addr  out  32  pb_addr of the first failing access.

## Operation

Address decode
- pb_addr[31]=0 → RAM. pb_addr[17]=1 selects SPRAM (addr = pb_addr[SPRAM_AW+1:2]); pb_addr[17]=0 selects BRAM (addr = pb_addr[BRAM_AW+1:2]).
- pb_addr[31]=1 → Wishbone. Slave index k = pb_addr[27:24]. k ≥ WB_N is unmapped.

FSM states: IDLE, RAM, WB, DONE.
- IDLE, pb_valid=1:
  - RAM access → RAM. bram_we/spram_we pulse this cycle only, gated by |pb_wstrb.
  - Mapped WB access → WB. Register addr, wdata, wmsk, we = |pb_wstrb, and one-hot cyc.
  - Unmapped WB access → DONE with error.
- RAM: count RAM_LAT−1 further cycles, then → DONE, capturing RAM rdata.
- WB:
  - wb_cyc[k] held until the cycle wb_ack[k]=1. Capture the OR of all slave rdata, zero-extended to 32 bits. → DONE.
  - Watchdog counter starts at 0 on entry. If the count reaches TIMEOUT with no ack: drop cyc, → DONE with timeout error.
  - An ack arriving in the same cycle the count reaches TIMEOUT wins; no error is raised.
- DONE: pb_ready=1 and pb_rdata = captured data for exactly one cycle. Error completions return 32'hFFFFFFFF. pb_valid is ignored in DONE. → IDLE.

Error capture
- On an error completion with err_flag=0: set err_flag, load err_code and err_addr.
- Later errors do not overwrite err_code/err_addr while err_flag=1.
- err_clr clears all three fields. If err_clr coincides with a new error, the new error is captured.

Other rules
- Writes complete exactly like reads; pb_rdata is don't-care for writes, but the registered value is still presented.
- pb_valid dropping mid-transaction (not legal for PicoRV32) does not abort; the transaction finishes normally.
- Any wb_ack from a non-selected slave is ignored.

## Timing
- Reset values: all outputs 0, FSM in IDLE, watchdog 0, error fields 0. Reset mid-transaction drops wb_cyc the next cycle and produces no pb_ready.
- RAM access: valid sampled at cycle 0, pb_ready at cycle RAM_LAT+1.
- WB access: valid at cycle 0, wb_cyc at cycle 1, ack at cycle A ≥ 1, wb_cyc low at A+1, pb_ready at A+1.
- Timeout: wb_cyc high for cycles 1..TIMEOUT, pb_ready at TIMEOUT+1.
- Unmapped access: pb_ready at cycle 1.
- Back-to-back accesses: a new request is accepted no earlier than the cycle after pb_ready.

## Test plan
- BRAM write 0x12345678 to 0x10 with strb 0xF, then read, RAM_LAT=1 → bram_we at cycle 0 with wmsk=0; read pb_ready at cycle 2 with rdata 0x12345678. With RAM_LAT=2, ready at cycle 3.
- SPRAM partial write to 0x00020004, strb 0x3 → spram_we=1, spram_wmsk=0xC, spram_addr=1, bram_we=0.
- WB read at 0x83000010, slave 3 acks at cycle 4 with 0xCAFEF00D (WB_DW=32, WB_AI=2) → wb_cyc=0x08 for cycles 1..4, wb_addr=4, pb_ready at cycle 5 with rdata 0xCAFEF00D.
- WB slave never acks, TIMEOUT=8 → cyc high for cycles 1..8, pb_ready at 9 with 0xFFFFFFFF, err_flag=1, err_code=01, err_addr=0x8X000000.
- Unmapped access to 0x8F000000 with WB_N=8 → ready at cycle 1 with 0xFFFFFFFF. With err_flag already set from a prior timeout, err_code stays 01. After err_clr, the next unmapped access sets err_code=10.
- Ack exactly at the TIMEOUT cycle → normal data returned, no error. Assert rst during a WB wait → cyc=0 next cycle, no ready pulse, error fields cleared.
